add64_sequencer: RTL and testbench

ADD64_SEQUENCER -- requirements
Module: add64_sequencer

---
 rtl/add64_sequencer_if.sv | 27 ++
 rtl/add64_sequencer.sv | 81 ++++++++
 tb/tb_add64_sequencer.sv | 128 ++++++++++++
 3 files changed

// File: rtl/add64_sequencer_if.sv
// add64_sequencer_if: input beat stream, external 64-bit adder bus and result beat stream.
interface add64_sequencer_if #(parameter int CNT_W = 16);
    logic             in_valid;
    logic             in_ready;
    logic [31:0]      in_data;
    logic             in_cin;
    logic [63:0]      add_x;
    logic [63:0]      add_y;
    logic             add_cin;
    logic [63:0]      add_sum;
    logic             add_cout;
    logic             out_valid;
    logic             out_ready;
    logic [31:0]      out_data;
    logic             out_last;
    logic             out_cout;
    logic             out_ovf;
    logic [CNT_W-1:0] op_count;
    modport master (
        input  in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
        output in_ready, add_x, add_y, add_cin, out_valid, out_data, out_last, out_cout, out_ovf, op_count
    );
    modport slave (
        output in_valid, in_data, in_cin, add_sum, add_cout, out_ready,
        input  in_ready, add_x, add_y, add_cin, out_valid, out_data, out_last, out_cout, out_ovf, op_count
    );
endinterface

// File: rtl/add64_sequencer.sv
// add64_sequencer: loads two 64-bit operands as four 32-bit beats, runs them through an
// external adder for one cycle, and returns the sum as two 32-bit beats with carry/overflow.
module add64_sequencer #(parameter int CNT_W = 16) (
    input  logic              clk,
    input  logic              rst_n,
    add64_sequencer_if.master bus
);
    typedef enum logic [1:0] {LOAD, EXEC, OUT_LO, OUT_HI} state_t;
    state_t           state_q, state_d;
    logic [1:0]       beat_q, beat_d;
    logic [63:0]      x_q, x_d, y_q, y_d, sum_q, sum_d;
    logic             cin_q, cin_d, cout_q, cout_d, ovf_q, ovf_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= LOAD;
            beat_q  <= '0;
            x_q     <= '0;
            y_q     <= '0;
            cin_q   <= 1'b0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            ovf_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            x_q     <= x_d;
            y_q     <= y_d;
            cin_q   <= cin_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            ovf_q   <= ovf_d;
            cnt_q   <= cnt_d;
        end
    end
    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        x_d     = x_q;
        y_d     = y_q;
        cin_d   = cin_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        ovf_d   = ovf_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD: if (bus.in_valid) begin
                beat_d = beat_q + 2'd1;
                x_d = {beat_q == 2'd1 ? bus.in_data : x_q[63:32], beat_q == 2'd0 ? bus.in_data : x_q[31:0]};
                y_d = {beat_q == 2'd3 ? bus.in_data : y_q[63:32], beat_q == 2'd2 ? bus.in_data : y_q[31:0]};
                if (beat_q == 2'd3) begin
                    cin_d   = bus.in_cin;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                sum_d   = bus.add_sum;
                cout_d  = bus.add_cout;
                ovf_d   = (x_q[63] == y_q[63]) && (bus.add_sum[63] != x_q[63]);
                state_d = OUT_LO;
            end
            OUT_LO: if (bus.out_ready) state_d = OUT_HI;
            default: if (bus.out_ready) begin
                cnt_d   = cnt_q + CNT_W'(1);
                beat_d  = 2'd0;
                state_d = LOAD;
            end
        endcase
    end
    assign bus.in_ready  = state_q == LOAD;
    assign bus.add_x     = x_q;
    assign bus.add_y     = y_q;
    assign bus.add_cin   = cin_q;
    assign bus.out_valid = state_q == OUT_LO || state_q == OUT_HI;
    assign bus.out_last  = state_q == OUT_HI;
    assign bus.out_data  = state_q == OUT_HI ? sum_q[63:32] : state_q == OUT_LO ? sum_q[31:0] : 32'd0;
    assign bus.out_cout  = cout_q;
    assign bus.out_ovf   = ovf_q;
    assign bus.op_count  = cnt_q;
endmodule

// File: tb/tb_add64_sequencer.sv
// tb_add64_sequencer: directed operand vectors through the sequencer with a behavioural adder.
module tb_add64_sequencer;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int   pass = 0;
    int   total = 0;
    add64_sequencer_if #(.CNT_W(2)) b();
    add64_sequencer #(.CNT_W(2)) dut (.clk(clk), .rst_n(rst_n), .bus(b));
    always #5 clk = ~clk;
    assign {b.add_cout, b.add_sum} = {1'b0, b.add_x} + {1'b0, b.add_y} + {64'd0, b.add_cin};
    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got === exp) pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask
    task automatic put(input logic [31:0] d, input logic c);
        int n = 0;
        @(negedge clk);
        b.in_valid = 1'b1;
        b.in_data  = d;
        b.in_cin   = c;
        while (!b.in_ready && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n == 20) chk("in_timeout", 0, 1);
        @(posedge clk);
        #1 b.in_valid = 1'b0;
    endtask
    // carry-in is inverted on the first three beats so only the 4th-beat sample matters
    task automatic op(input logic [63:0] x, input logic [63:0] y, input logic c);
        put(x[31:0], ~c);
        put(x[63:32], ~c);
        put(y[31:0], ~c);
        put(y[63:32], c);
    endtask
    task automatic get(input logic [63:0] s, input logic c, input logic o, input bit hold);
        int n = 0;
        @(negedge clk);
        while (!b.out_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk("out_timeout", b.out_valid, 1);
        for (int h = 0; h < 2; h++) begin
            for (int i = 0; i < (hold ? 5 : 0); i++) begin
                chk("hold_data", b.out_data, h ? s[63:32] : s[31:0]);
                chk("hold_valid", b.out_valid, 1);
                chk("hold_in_ready", b.in_ready, 0);
                @(negedge clk);
            end
            chk(h ? "data_hi" : "data_lo", b.out_data, h ? s[63:32] : s[31:0]);
            chk("last", b.out_last, h);
            if (h == 1) begin
                chk("cout", b.out_cout, c);
                chk("ovf", b.out_ovf, o);
            end
            b.out_ready = 1'b1;
            @(posedge clk);
            #1 b.out_ready = 1'b0;
            @(negedge clk);
        end
        chk("back_to_load", b.in_ready, 1);
        chk("no_valid", b.out_valid, 0);
    endtask
    initial begin
        b.in_valid  = 1'b0;
        b.in_data   = '0;
        b.in_cin    = 1'b0;
        b.out_ready = 1'b1;
        #1;
        chk("rst_in_ready", b.in_ready, 1);
        chk("rst_out_valid", b.out_valid, 0);
        chk("rst_out_data", b.out_data, 0);
        chk("rst_out_last", b.out_last, 0);
        chk("rst_add_x", b.add_x, 0);
        chk("rst_add_y", b.add_y, 0);
        chk("rst_op_count", b.op_count, 0);
        @(negedge clk);
        rst_n = 1'b1;
        b.out_ready = 1'b0;
        op(64'd1, 64'd1, 1'b0);
        chk("add_x", b.add_x, 64'd1);
        chk("add_y", b.add_y, 64'd1);
        chk("add_cin", b.add_cin, 0);
        @(negedge clk);
        chk("exec_no_valid", b.out_valid, 0);
        @(negedge clk);
        chk("latency_valid", b.out_valid, 1);
        get(64'd2, 1'b0, 1'b0, 1'b0);
        chk("count1", b.op_count, 1);
        op(64'd200, 64'd400, 1'b0);
        get(64'd600, 1'b0, 1'b0, 1'b0);
        op(64'd9999999, 64'd1, 1'b1);
        get(64'd10000001, 1'b0, 1'b0, 1'b0);
        chk("count3", b.op_count, 3);
        op(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        get(64'd0, 1'b1, 1'b0, 1'b0);
        chk("count_wrap", b.op_count, 0);
        op(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0);
        get(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0);
        op(64'h0000_0001_FFFF_FFFF, 64'd1, 1'b0);
        get(64'h0000_0002_0000_0000, 1'b0, 1'b0, 1'b1);
        chk("count_stall", b.op_count, 2);
        put(32'hDEAD_BEEF, 1'b0);
        put(32'h1234_5678, 1'b0);
        chk("partial_x", b.add_x, 64'h1234_5678_DEAD_BEEF);
        @(negedge clk);
        rst_n = 1'b0;
        b.in_valid = 1'b1;
        b.in_data  = 32'h55;
        #1;
        chk("mid_rst_add_x", b.add_x, 0);
        chk("mid_rst_count", b.op_count, 0);
        chk("mid_rst_in_ready", b.in_ready, 1);
        chk("mid_rst_out_valid", b.out_valid, 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_beat_ignored", b.add_x, 0);
        b.in_valid = 1'b0;
        rst_n = 1'b1;
        op(64'd3, 64'd4, 1'b0);
        get(64'd7, 1'b0, 1'b0, 1'b0);
        chk("count_after_rst", b.op_count, 1);
        $display("%0d/%0d checks passed", pass, total);
        $finish;
    end
endmodule
